player_ctl: RTL

Player movement controller. Converts left/right button levels into the horizontal position, vertical offset and facing state of the player sprite, updating once per video frame. Sits directly upstream of the player drawing stage and drives its `xpos_player`, `ypos_player` and `state` inputs. Clocked in the pixel clock domain and frame-locked to the VGA timing's vsync.

---
 rtl/state_pkg.sv | 13 +
 rtl/vga_pkg.sv | 7 +
 rtl/frame_tick.sv | 34 +++
 rtl/player_ctl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/state_pkg.sv
// Player facing state and sprite geometry shared by game logic and the draw stage.
package state_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } State;

    localparam int unsigned PLAYER_WIDTH  = 40;
    localparam int unsigned PLAYER_HEIGHT = 80;

endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants shared by the video pipeline.
package vga_pkg;

    localparam int unsigned HOR_PIXELS = 800;
    localparam int unsigned VER_PIXELS = 600;

endpackage

// File: rtl/frame_tick.sv
// Registers vsync and emits a one-cycle tick on each rising edge (frame-rate strobe).
module frame_tick (
    input  logic clk,
    input  logic rst,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_q, vsync_d;
    logic vsync_prev_q, vsync_prev_d;
    logic armed_q, armed_d;

    // armed blocks a tick from a vsync that was already high when reset released
    always_comb begin
        vsync_d      = vsync_in;
        vsync_prev_d = vsync_q;
        armed_d      = armed_q | ~vsync_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            vsync_q      <= vsync_d;
            vsync_prev_q <= vsync_prev_d;
            armed_q      <= armed_d;
        end
    end

    assign tick = vsync_q & ~vsync_prev_q & armed_q;

endmodule

// File: rtl/player_ctl.sv
// Player movement controller: buttons -> x position / facing state, updated once per frame.
// Optional acceleration enabled by defining PLAYER_CTL_ACCEL_EN.
module player_ctl
    import state_pkg::*;
#(
    parameter int unsigned X_MIN     = 0,
    parameter int unsigned X_MAX     = vga_pkg::HOR_PIXELS - PLAYER_WIDTH,
    parameter int unsigned X_START   = 380,
    parameter int unsigned Y_START   = 0,
    parameter int unsigned STEP      = 2,
    parameter int unsigned MAX_SPEED = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [11:0] xpos_player,
    output logic [11:0] ypos_player,
    output State        state
);

    localparam logic [12:0] X_MIN_W   = 13'(X_MIN);
    localparam logic [12:0] X_MAX_W   = 13'(X_MAX);
    localparam logic [11:0] X_MIN_12  = 12'(X_MIN);
    localparam logic [11:0] X_MAX_12  = 12'(X_MAX);
    localparam logic [11:0] X_START_12 = 12'(X_START);
    localparam logic [11:0] Y_START_12 = 12'(Y_START);

    logic btn_l_meta_q, btn_l_meta_d, btn_l_sync_q, btn_l_sync_d;
    logic btn_r_meta_q, btn_r_meta_d, btn_r_sync_q, btn_r_sync_d;
    logic [11:0] xpos_q, xpos_d;
    logic [11:0] ypos_q, ypos_d;
    State state_q, state_d;
    State dir;
    logic tick;
    logic [12:0] step_w;
    logic [12:0] sum_w;

    frame_tick u_frame_tick (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    always_comb begin
        btn_l_meta_d = btn_left;
        btn_l_sync_d = btn_l_meta_q;
        btn_r_meta_d = btn_right;
        btn_r_sync_d = btn_r_meta_q;
    end

    always_comb begin
        dir = IDLE;
        unique case ({btn_l_sync_q, btn_r_sync_q})
            2'b10:   dir = LEFT;
            2'b01:   dir = RIGHT;
            default: dir = IDLE;
        endcase
    end

`ifdef PLAYER_CTL_ACCEL_EN
    localparam logic [2:0] MAX_SPEED_W = 3'(MAX_SPEED);

    logic [2:0] speed_q, speed_d;

    // the updated speed is applied to the move on the same tick
    always_comb begin
        speed_d = speed_q;
        if (tick) begin
            if (dir == IDLE)
                speed_d = '0;
            else if (dir == state_q)
                speed_d = (speed_q >= MAX_SPEED_W) ? MAX_SPEED_W : speed_q + 3'd1;
            else
                speed_d = 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) speed_q <= '0;
        else     speed_q <= speed_d;
    end

    assign step_w = {10'b0, speed_d};
`else
    assign step_w = 13'(STEP);
`endif

    // compare before subtract so the left move never underflows
    always_comb begin
        sum_w   = {1'b0, xpos_q} + step_w;
        xpos_d  = xpos_q;
        state_d = state_q;
        ypos_d  = Y_START_12;
        if (tick) begin
            state_d = dir;
            unique case (dir)
                RIGHT:   xpos_d = (sum_w > X_MAX_W) ? X_MAX_12 : sum_w[11:0];
                LEFT:    xpos_d = ({1'b0, xpos_q} < X_MIN_W + step_w) ? X_MIN_12
                                                                       : xpos_q - step_w[11:0];
                default: xpos_d = xpos_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_l_meta_q <= 1'b0;
            btn_l_sync_q <= 1'b0;
            btn_r_meta_q <= 1'b0;
            btn_r_sync_q <= 1'b0;
            xpos_q       <= X_START_12;
            ypos_q       <= Y_START_12;
            state_q      <= IDLE;
        end else begin
            btn_l_meta_q <= btn_l_meta_d;
            btn_l_sync_q <= btn_l_sync_d;
            btn_r_meta_q <= btn_r_meta_d;
            btn_r_sync_q <= btn_r_sync_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            state_q      <= state_d;
        end
    end

    assign xpos_player = xpos_q;
    assign ypos_player = ypos_q;
    assign state       = state_q;

endmodule
